// File: rtl/cc_pkg.sv
// Shared definitions for the code-converter request sequencer: op codes,
// request/result widths, FSM state type and an op legality helper.
package cc_pkg;

  localparam int unsigned CC_OP_W   = 4;
  localparam int unsigned CC_DATA_W = 4;
  localparam int unsigned CC_RES_W  = 8;

  localparam logic [CC_OP_W-1:0] CC_OP_GRAY = 4'b0001;
  localparam logic [CC_OP_W-1:0] CC_OP_XS3  = 4'b0010;
  localparam logic [CC_OP_W-1:0] CC_OP_XS5  = 4'b0100;
  localparam logic [CC_OP_W-1:0] CC_OP_BCD  = 4'b1000;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StHold
  } cc_state_e;

  // Field order matches the converter input word {operand, op}.
  typedef struct packed {
    logic [CC_DATA_W-1:0] data;
    logic [CC_OP_W-1:0]   op;
  } cc_req_t;

  function automatic logic cc_op_legal(input logic [CC_OP_W-1:0] op);
    logic legal;
    case (op)
      CC_OP_GRAY, CC_OP_XS3, CC_OP_XS5, CC_OP_BCD: legal = 1'b1;
      default:                                     legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/cc_req_fifo.sv
// Synchronous request FIFO with async active-low reset. Depth must be a power
// of two so the pointers wrap naturally.
module cc_req_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             wr_en, rd_en;

  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);
  // A push while full is dropped even if a pop happens in the same cycle.
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rdata = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + PtrW'(1);
      if (rd_en) rptr_q <= rptr_q + PtrW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/cc_request_sequencer.sv
// Queues conversion requests and issues them one at a time to an external code
// converter, returning results in order. Define CC_SEQ_OP_CHECK_EN to reject
// non-one-hot ops without issuing them.
module cc_request_sequencer
  import cc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned DONE_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CC_OP_W-1:0]   req_op,
  input  logic [CC_DATA_W-1:0] req_data,
  output logic [CC_RES_W-1:0]  cc_a_out,
  output logic                 cc_en_n_out,
  input  logic [CC_RES_W-1:0]  cc_y_in,
  input  logic                 cc_done_in,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CC_RES_W-1:0]  rsp_data,
  output logic                 rsp_err
);

  localparam int unsigned TmoW = $clog2(DONE_TIMEOUT + 1);

  cc_state_e           state_q, state_d;
  cc_req_t             issue_q, issue_d;
  logic [CC_RES_W-1:0] rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;

  cc_req_t fifo_wdata, fifo_rdata;
  logic    fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign fifo_wdata = '{data: req_data, op: req_op};
  // Held low while in reset so nothing is accepted before the queue is live.
  assign req_ready  = rst_n && !fifo_full;
  assign fifo_push  = req_valid && req_ready;

  cc_req_fifo #(
    .Width ($bits(cc_req_t)),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    issue_d     = issue_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    tmo_d       = tmo_q;
    fifo_pop    = 1'b0;
    cc_en_n_out = 1'b1;
    cc_a_out    = '0;
    rsp_valid   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) fifo_pop = 1'b1;
      end
      StIssue: begin
        cc_en_n_out = 1'b0;
        cc_a_out    = issue_q;
        tmo_d       = '0;
        if (cc_done_in) begin
          rsp_data_d = cc_y_in;
          rsp_err_d  = 1'b0;
          state_d    = StHold;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        cc_en_n_out = 1'b0;
        cc_a_out    = issue_q;
        if (cc_done_in) begin
          rsp_data_d = cc_y_in;
          rsp_err_d  = 1'b0;
          state_d    = StHold;
        end else if (tmo_q == TmoW'(DONE_TIMEOUT - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = StHold;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StHold: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          if (fifo_empty) state_d = StIdle;
          else            fifo_pop = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Shared by IDLE and HOLD: load the head request and go straight to issue.
    if (fifo_pop) begin
      issue_d = fifo_rdata;
      state_d = StIssue;
`ifdef CC_SEQ_OP_CHECK_EN
      if (!cc_op_legal(fifo_rdata.op)) begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b1;
        state_d    = StHold;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      issue_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      issue_q    <= issue_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      tmo_q      <= tmo_d;
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule
